// File: rtl/scoreboard_checker.sv
// Scoreboard checker: compares observed samples against the head of an external
// expected-sample FIFO, keeps saturating statistics, a watchdog, and a verdict.
module scoreboard_checker #(
  parameter int BITS     = -1,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                eot,
  input  logic                act_valid,
  input  logic [BITS-1:0]     act_data,
  input  logic [BITS-1:0]     exp_rdata,
  input  logic                exp_empty,
  output logic                exp_deq,
  output logic [CNT_BITS-1:0] match_cnt,
  output logic [CNT_BITS-1:0] mismatch_cnt,
  output logic [CNT_BITS-1:0] unexp_cnt,
  output logic [BITS-1:0]     first_exp,
  output logic [BITS-1:0]     first_act,
  output logic                timeout,
  output logic                done,
  output logic                pass
);

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] match_q, match_d;
  logic [CNT_BITS-1:0] mismatch_q, mismatch_d;
  logic [CNT_BITS-1:0] unexp_q, unexp_d;
  logic [BITS-1:0]     first_exp_q, first_exp_d;
  logic [BITS-1:0]     first_act_q, first_act_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                timeout_q, timeout_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                active;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign exp_deq = active && act_valid && !exp_empty;

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    mismatch_d  = mismatch_q;
    unexp_d     = unexp_q;
    first_exp_d = first_exp_q;
    first_act_d = first_act_q;
    idle_d      = idle_q;
    timeout_d   = timeout_q;

    if (exp_deq) begin
      if (act_data == exp_rdata) begin
        match_d = sat_inc(match_q);
      end else begin
        mismatch_d = sat_inc(mismatch_q);
        // mismatch_cnt saturates rather than wraps, so zero means "no mismatch yet"
        if (mismatch_q == '0) begin
          first_exp_d = exp_rdata;
          first_act_d = act_data;
        end
      end
    end else if (active && act_valid) begin
      unexp_d = sat_inc(unexp_q);
    end

    if (active && !timeout_q) begin
      if (act_valid || exp_empty) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
        if (idle_d == IDLE_W'(TIMEOUT)) timeout_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (eot) state_d = DRAIN;
      DRAIN:   if (exp_empty || timeout_q) state_d = DONE;
      default: state_d = DONE;
    endcase

    done_d = (state_d == DONE);
    pass_d = done_d && (mismatch_d == '0) && (unexp_d == '0) && !timeout_d && (match_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      match_q     <= '0;
      mismatch_q  <= '0;
      unexp_q     <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      idle_q      <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      unexp_q     <= unexp_d;
      first_exp_q <= first_exp_d;
      first_act_q <= first_act_d;
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign unexp_cnt    = unexp_q;
  assign first_exp    = first_exp_q;
  assign first_act    = first_act_q;
  assign timeout      = timeout_q;
  assign done         = done_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_scoreboard_checker.sv
// Bench for scoreboard_checker: two instances (wide and 2-bit counters) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_scoreboard_checker;

  localparam int TMO = 8;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, eot, act_valid, exp_empty;
  logic [7:0] act_data, exp_rdata;

  logic       exp_deq_a, timeout_a, done_a, pass_a;
  logic [7:0] match_a, mism_a, unexp_a, fexp_a, fact_a;
  logic       exp_deq_b, timeout_b, done_b, pass_b;
  logic [1:0] match_b, mism_b, unexp_b;
  logic [7:0] fexp_b, fact_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo[$];
  int  m_phase, m_match, m_mism, m_unexp, m_idle;
  bit  m_to;
  logic [7:0] m_fe, m_fa;
  int  dut_deq;

  always #5 clk = ~clk;

  scoreboard_checker #(.BITS(8), .TIMEOUT(TMO), .CNT_BITS(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .eot(eot), .act_valid(act_valid),
    .act_data(act_data), .exp_rdata(exp_rdata), .exp_empty(exp_empty), .exp_deq(exp_deq_a),
    .match_cnt(match_a), .mismatch_cnt(mism_a), .unexp_cnt(unexp_a),
    .first_exp(fexp_a), .first_act(fact_a), .timeout(timeout_a), .done(done_a), .pass(pass_a));

  scoreboard_checker #(.BITS(8), .TIMEOUT(TMO), .CNT_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .eot(eot), .act_valid(act_valid),
    .act_data(act_data), .exp_rdata(exp_rdata), .exp_empty(exp_empty), .exp_deq(exp_deq_b),
    .match_cnt(match_b), .mismatch_cnt(mism_b), .unexp_cnt(unexp_b),
    .first_exp(fexp_b), .first_act(fact_b), .timeout(timeout_b), .done(done_b), .pass(pass_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic refresh_fifo();
    exp_empty = (fifo.size() == 0);
    exp_rdata = exp_empty ? 8'h00 : fifo[0];
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_match = 0; m_mism = 0; m_unexp = 0; m_idle = 0;
    m_to = 1'b0; m_fe = 8'h00; m_fa = 8'h00;
  endtask

  task automatic check_outputs();
    bit m_done, m_pass;
    m_done = (m_phase == P_DONE);
    m_pass = m_done && m_mism == 0 && m_unexp == 0 && !m_to && m_match > 0;
    chk("match_a", match_a, sat(m_match, 255));
    chk("mism_a", mism_a, sat(m_mism, 255));
    chk("unexp_a", unexp_a, sat(m_unexp, 255));
    chk("first_exp_a", fexp_a, m_fe);
    chk("first_act_a", fact_a, m_fa);
    chk("timeout_a", timeout_a, m_to);
    chk("done_a", done_a, m_done);
    chk("pass_a", pass_a, m_pass);
    chk("match_b", match_b, sat(m_match, 3));
    chk("mism_b", mism_b, sat(m_mism, 3));
    chk("unexp_b", unexp_b, sat(m_unexp, 3));
    chk("first_exp_b", fexp_b, m_fe);
    chk("first_act_b", fact_b, m_fa);
    chk("done_b", done_b, m_done);
    chk("pass_b", pass_b, m_pass);
  endtask

  // One clock: check the combinational pop mid-cycle, then advance the model.
  task automatic cycle();
    bit was_active, deq_m, empty, to_old;
    @(negedge clk);
    was_active = (m_phase == P_RUN) || (m_phase == P_DRAIN);
    empty = (fifo.size() == 0);
    deq_m = was_active && act_valid && !empty;
    chk("exp_deq_a", exp_deq_a, deq_m);
    chk("exp_deq_b", exp_deq_b, deq_m);
    if (exp_deq_a === 1'b1) dut_deq++;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      to_old = m_to;
      if (was_active && act_valid) begin
        if (!empty) begin
          if (act_data == fifo[0]) m_match++;
          else begin
            if (m_mism == 0) begin m_fe = fifo[0]; m_fa = act_data; end
            m_mism++;
          end
        end else m_unexp++;
      end
      if (was_active && !m_to) begin
        if (act_valid || empty) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TMO) m_to = 1'b1;
        end
      end
      case (m_phase)
        P_IDLE:  if (start) m_phase = P_RUN;
        P_RUN:   if (eot) m_phase = P_DRAIN;
        P_DRAIN: if (empty || to_old) m_phase = P_DONE;
        default: m_phase = P_DONE;
      endcase
    end
    if (deq_m) void'(fifo.pop_front());
    refresh_fifo();
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; eot = 1'b0; act_valid = 1'b0; act_data = 8'h00;
    fifo.delete();
    refresh_fifo();
    cycle();
    cycle();
    rst_n = 1'b1;
    dut_deq = 0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_done", done_a, 1'b1);
  endtask

  initial begin
    int n, len, steps;
    model_reset();
    dut_deq = 0;

    // Reset state
    do_reset();
    chk("rst_match", match_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);

    // Five in-order matches; 2-bit instance saturates at 3
    for (int i = 1; i <= 5; i++) fifo.push_back(8'(i));
    refresh_fifo();
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      act_valid = 1'b1; act_data = 8'(i); cycle();
    end
    act_valid = 1'b0; eot = 1'b1; cycle(); eot = 1'b0;
    run_to_done(10);
    chk("r24_match", match_a, 5);
    chk("r24_mism", mism_a, 0);
    chk("r24_pass", pass_a, 1);
    chk("r24_deq", dut_deq, 5);
    chk("r29_sat", match_b, 3);

    // Mismatches: first captured only
    do_reset();
    fifo.push_back(8'd10); fifo.push_back(8'd20); fifo.push_back(8'd30);
    refresh_fifo();
    start = 1'b1; cycle(); start = 1'b0;
    act_valid = 1'b1;
    act_data = 8'd10; cycle();
    act_data = 8'd99; cycle();
    act_data = 8'd31; cycle();
    act_valid = 1'b0; eot = 1'b1; cycle(); eot = 1'b0;
    run_to_done(10);
    chk("r25_match", match_a, 1);
    chk("r25_mism", mism_a, 2);
    chk("r25_fexp", fexp_a, 20);
    chk("r25_fact", fact_a, 99);
    chk("r25_pass", pass_a, 0);

    // Unexpected samples; start+eot together enters RUN only
    do_reset();
    start = 1'b1; eot = 1'b1; cycle(); start = 1'b0; eot = 1'b0;
    cycle(); cycle();
    chk("r19_not_done", done_a, 0);
    act_valid = 1'b1; act_data = 8'h3c; cycle(); cycle();
    act_valid = 1'b0; cycle();
    chk("r19_still_run", done_a, 0);
    eot = 1'b1; cycle(); eot = 1'b0;
    cycle();
    chk("r20_done", done_a, 1);
    chk("r26_unexp", unexp_a, 2);
    chk("r26_deq", dut_deq, 0);
    chk("r26_pass", pass_a, 0);

    // Watchdog with one sample pending
    do_reset();
    fifo.push_back(8'h55); refresh_fifo();
    start = 1'b1; cycle(); start = 1'b0;
    eot = 1'b1;
    n = 0;
    while (timeout_a !== 1'b1 && n < 20) begin
      cycle(); eot = 1'b0; n++;
    end
    chk("r27_edges", n, TMO);
    chk("r27_done_early", done_a, 0);
    cycle();
    chk("r27_done", done_a, 1);
    chk("r27_pass", pass_a, 0);
    chk("r27_timeout", timeout_a, 1);

    // Reset mid-run loses statistics and blocks pops
    do_reset();
    for (int i = 0; i < 5; i++) fifo.push_back(8'h77);
    refresh_fifo();
    start = 1'b1; cycle(); start = 1'b0;
    act_valid = 1'b1; act_data = 8'h77;
    cycle(); cycle(); cycle();
    chk("r28_pre", match_a, 3);
    act_valid = 1'b0; rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("r28_match", match_a, 0);
    dut_deq = 0;
    act_valid = 1'b1;
    cycle(); cycle(); cycle();
    act_valid = 1'b0;
    chk("r28_nodeq", dut_deq, 0);
    chk("r28_nocount", match_a, 0);

    // Randomized runs against the model
    for (int it = 0; it < 12; it++) begin
      do_reset();
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) fifo.push_back(8'($urandom));
      refresh_fifo();
      for (int i = 0; i < 2; i++) begin
        act_valid = 1'($urandom); act_data = 8'($urandom); cycle();
      end
      start = 1'b1; eot = 1'($urandom); act_valid = 1'b0; cycle();
      start = 1'b0;
      steps = $urandom_range(3, 12);
      for (int k = 0; k <= steps; k++) begin
        act_valid = ($urandom_range(0, 2) != 0);
        act_data = (fifo.size() != 0 && $urandom_range(0, 2) != 0) ? fifo[0] : 8'($urandom);
        eot = (k == steps);
        cycle();
      end
      eot = 1'b0;
      n = 0;
      while (done_a !== 1'b1 && n < 40) begin
        act_valid = 1'($urandom);
        act_data = (fifo.size() != 0 && $urandom_range(0, 2) != 0) ? fifo[0] : 8'($urandom);
        cycle();
        n++;
      end
      chk("rand_done", done_a, 1'b1);
      act_valid = 1'b1; act_data = 8'($urandom);
      cycle(); cycle();
      act_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_checker.md
SCOREBOARD_CHECKER -- requirements
Module: scoreboard_checker

Interface
REQ-001 SHALL have parameter BITS, default -1 (must be overridden), width of one compared sample.
REQ-002 SHALL have parameter TIMEOUT, default 1000, idle cycles allowed while expected data is pending.
REQ-003 SHALL have parameter CNT_BITS, default 32, width of every statistics counter.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 Port list (name  direction  width  meaning):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin checking.
- eot  input  1  end of test: stimulus finished.
- act_valid  input  1  DUT monitor presents an observed sample.
- act_data  input  BITS  observed sample.
- exp_rdata  input  BITS  head of expected-sample FIFO.
- exp_empty  input  1  expected FIFO empty.
- exp_deq  output  1  pop expected FIFO head.
- match_cnt  output  CNT_BITS  samples compared equal.
- mismatch_cnt  output  CNT_BITS  samples compared unequal.
- unexp_cnt  output  CNT_BITS  observed samples arriving with FIFO empty.
- first_exp  output  BITS  expected value of first mismatch.
- first_act  output  BITS  observed value of first mismatch.
- timeout  output  1  sticky watchdog expiry.
- done  output  1  check complete.
- pass  output  1  verdict, valid when done=1.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-007 IDLE->RUN when start=1; RUN->DRAIN when eot=1; DRAIN->DONE when exp_empty=1 or timeout=1; DONE is held until reset.
REQ-008 exp_deq SHALL be combinational: exp_deq = act_valid && !exp_empty && state in {RUN, DRAIN}; no deq in IDLE or DONE.
REQ-009 Comparison SHALL occur in the same cycle as exp_deq, comparing act_data to exp_rdata over all BITS; statistics update on the following clock edge (1-cycle latency).
REQ-010 Equal: match_cnt += 1. Unequal: mismatch_cnt += 1.
REQ-011 act_valid with exp_empty=1 in RUN/DRAIN: unexp_cnt += 1, no deq.
REQ-012 act_valid in IDLE or DONE SHALL be ignored: no count change.
REQ-013 first_exp/first_act SHALL capture exp_rdata/act_data on the first mismatch only; later mismatches leave them unchanged.
REQ-014 All counters SHALL saturate at 2^CNT_BITS-1; no wrap-around.
REQ-015 Watchdog: in RUN/DRAIN, idle counter increments each cycle with exp_empty=0 and act_valid=0; it clears on act_valid=1 or exp_empty=1.
REQ-016 timeout SHALL set on the edge where the idle counter reaches TIMEOUT, stay set until reset, and freeze the idle counter.
REQ-017 done=1 exactly when state is DONE.
REQ-018 pass SHALL be 1 only when done=1, mismatch_cnt=0, unexp_cnt=0, timeout=0, and match_cnt>0; otherwise 0.
REQ-019 start and eot in the same cycle while in IDLE SHALL go to RUN only; eot is acted on from the next cycle if still asserted.
REQ-020 Reaching DRAIN with exp_empty=1 SHALL go to DONE on the next edge.

Reset
REQ-021 rst_n=0 sampled at a rising clk edge SHALL reset:
- state to IDLE;
- all counters, first_exp, first_act, timeout, done and pass to 0.
REQ-022 Reset asserted mid-RUN/DRAIN SHALL abort checking, lose all statistics, and hold exp_deq=0 while state is IDLE.
REQ-023 No output SHALL be X after the first reset edge.

Verification
REQ-024 Start; 5 expected samples 1..5 queued; act 1..5 one per cycle; eot -> match_cnt=5, mismatch_cnt=0, done=1, pass=1, 5 deq pulses.
REQ-025 Expected 10,20,30; act 10,99,31 -> match_cnt=1, mismatch_cnt=2, first_exp=20, first_act=99, pass=0.
REQ-026 FIFO empty; 2 act_valid pulses in RUN -> unexp_cnt=2, exp_deq never 1, pass=0 at done.
REQ-027 TIMEOUT=8; 1 expected sample pending, no act_valid; eot -> timeout=1 on the 8th idle edge, DONE next edge, pass=0.
REQ-028 rst_n=0 for one edge after 3 matches in RUN -> all counters 0, state IDLE; act_valid afterwards with start=0 -> no counting, no deq.
REQ-029 CNT_BITS=2; 5 matches -> match_cnt holds at 3.
